// File: rtl/neuron_mac_if.sv
`timescale 1ns/1ps
// neuron_mac_if: RAM port bundle between the neuron stage (master)
// and the weight/activation RAM (slave).
interface neuron_mac_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16
);
   logic                  ram_we;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [DATA_WIDTH-1:0] ram_din;
   logic [DATA_WIDTH-1:0] ram_dout;

   modport master (
      output ram_we,
      output ram_addr,
      output ram_din,
      input  ram_dout
   );

   modport slave (
      input  ram_we,
      input  ram_addr,
      input  ram_din,
      output ram_dout
   );
endinterface

// File: rtl/neuron_mac.sv
`timescale 1ns/1ps
// neuron_mac: signed fixed-point dot product plus bias with ReLU and
// saturation; operands read from and result written back to the RAM.
module neuron_mac #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16,
   parameter int FRAC_BITS  = 8,
   parameter int ACC_WIDTH  = 2*DATA_WIDTH+8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] x_base,
   input  logic [ADDR_WIDTH-1:0] w_base,
   input  logic [ADDR_WIDTH-1:0] out_addr,
   input  logic [ADDR_WIDTH:0]   num_inputs,
   input  logic [DATA_WIDTH-1:0] bias,
   neuron_mac_if.master          ram,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] result
);
   localparam int PW = 2*DATA_WIDTH;

   typedef enum logic [2:0] {
      IDLE, LD_X, LD_W, ACC_LAST, ACT, WRITE, DONE
   } state_t;

   state_t state, state_n;

   logic [ADDR_WIDTH-1:0] x_base_r;
   logic [ADDR_WIDTH-1:0] w_base_r;
   logic [ADDR_WIDTH-1:0] out_addr_r;
   logic [ADDR_WIDTH:0]   n_r;
   logic [ADDR_WIDTH:0]   i_r;
   logic [DATA_WIDTH-1:0] bias_r;
   logic [DATA_WIDTH-1:0] x_reg;
   logic [DATA_WIDTH-1:0] result_next;
   logic [ACC_WIDTH-1:0]  acc;

   logic [ADDR_WIDTH:0]          i_inc;
   logic signed [PW-1:0]         prod;
   logic [ACC_WIDTH-1:0]         prod_ext;
   logic [ACC_WIDTH-1:0]         bias_sh;
   logic [ACC_WIDTH-1:0]         act_sum;
   logic signed [ACC_WIDTH-1:0]  act_shift;
   logic [DATA_WIDTH-1:0]        act_val;

   logic                  we_n;
   logic [ADDR_WIDTH-1:0] addr_n;
   logic [DATA_WIDTH-1:0] din_n;

   assign i_inc     = i_r + {{ADDR_WIDTH{1'b0}}, 1'b1};
   assign prod      = $signed(x_reg) * $signed(ram.ram_dout);
   assign prod_ext  = {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
   assign bias_sh   = {{(ACC_WIDTH-DATA_WIDTH){bias_r[DATA_WIDTH-1]}},
                       bias_r} << FRAC_BITS;
   assign act_sum   = acc + bias_sh;
   assign act_shift = $signed(act_sum) >>> FRAC_BITS;

   assign busy = (state != IDLE) && (state != DONE);
   assign done = (state == DONE);

   // ReLU then clamp to the largest positive data value
   always_comb begin
      act_val = act_shift[DATA_WIDTH-1:0];
      if (act_shift[ACC_WIDTH-1])
         act_val = '0;
      else if (|act_shift[ACC_WIDTH-2:DATA_WIDTH-1])
         act_val = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   end

   // state register and registered RAM port
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         ram.ram_we   <= 1'b0;
         ram.ram_addr <= '0;
         ram.ram_din  <= '0;
      end else begin
         state        <= state_n;
         ram.ram_we   <= we_n;
         ram.ram_addr <= addr_n;
         ram.ram_din  <= din_n;
      end
   end

   // next state and next RAM address/strobe (one cycle ahead of use)
   always_comb begin
      state_n = state;
      we_n    = 1'b0;
      addr_n  = '0;
      din_n   = '0;
      unique case (state)
         IDLE: begin
            if (start) begin
               if (num_inputs != '0) begin
                  state_n = LD_X;
                  addr_n  = x_base;
               end else begin
                  state_n = ACT;
               end
            end
         end
         LD_X: begin
            state_n = LD_W;
            addr_n  = w_base_r + i_r[ADDR_WIDTH-1:0];
         end
         LD_W: begin
            if (i_inc < n_r) begin
               state_n = LD_X;
               addr_n  = x_base_r + i_inc[ADDR_WIDTH-1:0];
            end else begin
               state_n = ACC_LAST;
            end
         end
         ACC_LAST: state_n = ACT;
         ACT: begin
            state_n = WRITE;
            we_n    = 1'b1;
            addr_n  = out_addr_r;
            din_n   = act_val;
         end
         WRITE:   state_n = DONE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // operand latching, accumulation and result capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_base_r    <= '0;
         w_base_r    <= '0;
         out_addr_r  <= '0;
         n_r         <= '0;
         i_r         <= '0;
         bias_r      <= '0;
         x_reg       <= '0;
         result_next <= '0;
         result      <= '0;
         acc         <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  x_base_r   <= x_base;
                  w_base_r   <= w_base;
                  out_addr_r <= out_addr;
                  n_r        <= num_inputs;
                  bias_r     <= bias;
                  acc        <= '0;
                  i_r        <= '0;
               end
            end
            LD_X: begin
               if (i_r != '0)
                  acc <= acc + prod_ext;
            end
            LD_W: begin
               x_reg <= ram.ram_dout;
               i_r   <= i_inc;
            end
            ACC_LAST: acc <= acc + prod_ext;
            ACT:      result_next <= act_val;
            WRITE:    result <= result_next;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_neuron_mac.sv
`timescale 1ns/1ps
// tb_neuron_mac: table vectors, randomized operations against an
// arithmetic reference model, and start/reset control sequences.
module tb_neuron_mac;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  x_base = '0;
   logic [7:0]  w_base = '0;
   logic [7:0]  out_addr = '0;
   logic [8:0]  num_inputs = '0;
   logic [15:0] bias = '0;
   logic        busy, done;
   logic [15:0] result;

   neuron_mac_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) ram ();

   neuron_mac dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .x_base(x_base), .w_base(w_base), .out_addr(out_addr),
      .num_inputs(num_inputs), .bias(bias), .ram(ram),
      .busy(busy), .done(done), .result(result)
   );

   always #5 clk = ~clk;

   logic [15:0] mem [256];
   logic [15:0] shadow [256];
   logic        ld_en = 1'b0;
   logic [7:0]  ld_addr = '0;
   logic [15:0] ld_data = '0;
   int          we_cnt = 0;
   int          done_cnt = 0;
   logic [7:0]  wr_addr = '0;
   int          nvec = 0;
   int          nmis = 0;

   // RAM with registered read data
   always @(posedge clk) begin
      if (ld_en) mem[ld_addr] <= ld_data;
      else if (ram.ram_we) mem[ram.ram_addr] <= ram.ram_din;
      ram.ram_dout <= mem[ram.ram_addr];
   end

   // write and done pulse monitor
   always @(posedge clk) begin
      if (ram.ram_we) begin
         we_cnt  <= we_cnt + 1;
         wr_addr <= ram.ram_addr;
      end
      if (done) done_cnt <= done_cnt + 1;
   end

   typedef struct packed {
      logic [7:0]       xb, wb, oa;
      logic [8:0]       n;
      logic [15:0]      b;
      logic [3:0][15:0] xv, wv;
      logic [15:0]      ex;
   } vec_t;

   vec_t tv [7];

   function automatic vec_t mk(
      input logic [7:0] xb, wb, oa, input logic [8:0] n,
      input logic [15:0] b, x0, x1, x2, x3, w0, w1, w2, w3, ex);
      vec_t v;
      v.xb = xb; v.wb = wb; v.oa = oa; v.n = n; v.b = b;
      v.xv[0] = x0; v.xv[1] = x1; v.xv[2] = x2; v.xv[3] = x3;
      v.wv[0] = w0; v.wv[1] = w1; v.wv[2] = w2; v.wv[3] = w3;
      v.ex = ex;
      return v;
   endfunction

   // Q7.8 dot product + bias, floor, ReLU, saturate
   function automatic logic [15:0] model(
      input logic [7:0] xb, wb, input int n, input logic [15:0] b);
      longint s = 0;
      for (int i = 0; i < n; i++)
         s += longint'($signed(shadow[8'(xb + i)])) *
              longint'($signed(shadow[8'(wb + i)]));
      s += longint'($signed(b)) * 256;
      s = s >>> 8;
      if (s < 0) return 16'h0000;
      if (s > 32767) return 16'h7FFF;
      return s[15:0];
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic poke(input logic [7:0] a, input logic [15:0] d);
      ld_en = 1'b1; ld_addr = a; ld_data = d; shadow[a] = d;
      @(posedge clk); #1;
      ld_en = 1'b0;
   endtask

   task automatic run_op(input logic [7:0] xb, wb, oa,
                         input logic [8:0] n, input logic [15:0] b,
                         input logic [15:0] ex, input bit glitch);
      int k, w0, d0, bad, lat;
      logic [7:0] ea;
      w0 = we_cnt; d0 = done_cnt; bad = 0;
      lat = (n == 0) ? 3 : 2 * int'(n) + 4;
      x_base = xb; w_base = wb; out_addr = oa;
      num_inputs = n; bias = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      x_base = 8'($urandom); w_base = 8'($urandom);
      out_addr = 8'($urandom); bias = 16'($urandom);
      num_inputs = 9'($urandom_range(0, 9));
      k = 1;
      while (!done && k < 700) begin
         if (k <= 2 * int'(n)) begin
            ea = (k % 2 == 1) ? 8'(xb + (k - 1) / 2) : 8'(wb + k / 2 - 1);
            if (ram.ram_addr !== ea) bad++;
         end
         start = glitch && (k == 2);
         @(posedge clk); #1;
         k++;
      end
      start = 1'b0;
      chk("latency", k, lat);
      chk("result", result, ex);
      chk("mem_out", mem[oa], ex);
      chk("wr_addr", wr_addr, oa);
      if (n != 0) chk("rd_addr_errs", bad, 0);
      repeat (4) @(posedge clk);
      #1;
      chk("write_count", we_cnt - w0, 1);
      chk("done_count", done_cnt - d0, 1);
      chk("busy_after", busy, 1'b0);
      shadow[oa] = ex;
   endtask

   task automatic load_vec(input vec_t v);
      for (int i = 0; i < int'(v.n); i++) begin
         poke(8'(v.xb + i), v.xv[i]);
         poke(8'(v.wb + i), v.wv[i]);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      int w0, d0, n;
      logic [7:0] xb, wb, oa;
      logic [15:0] b, ex;

      tv[0] = mk(8'h10, 8'h20, 8'h30, 9'd3, 16'h0040,
                 16'h0100, 16'h0200, 16'hFF80, 16'h0,
                 16'h0080, 16'h0040, 16'h0200, 16'h0, 16'h0040);
      tv[1] = mk(8'h10, 8'h20, 8'h30, 9'd3, 16'hFF00,
                 16'h0100, 16'h0200, 16'hFF80, 16'h0,
                 16'h0080, 16'h0040, 16'h0200, 16'h0, 16'h0000);
      tv[2] = mk(8'h40, 8'h50, 8'h60, 9'd4, 16'h0000,
                 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF,
                 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
      tv[3] = mk(8'h00, 8'h00, 8'h31, 9'd0, 16'h0123,
                 16'h0, 16'h0, 16'h0, 16'h0,
                 16'h0, 16'h0, 16'h0, 16'h0, 16'h0123);
      tv[4] = mk(8'hFE, 8'h80, 8'h70, 9'd3, 16'h0000,
                 16'h0100, 16'h0100, 16'h0100, 16'h0,
                 16'h0100, 16'h0200, 16'h0300, 16'h0, 16'h0600);
      tv[5] = mk(8'hC0, 8'hC8, 8'h72, 9'd1, 16'hFFFF,
                 16'h7FFF, 16'h0, 16'h0, 16'h0,
                 16'h0100, 16'h0, 16'h0, 16'h0, 16'h7FFE);
      tv[6] = mk(8'hC0, 8'hC8, 8'h73, 9'd1, 16'h0001,
                 16'h7FFF, 16'h0, 16'h0, 16'h0,
                 16'h0100, 16'h0, 16'h0, 16'h0, 16'h7FFF);

      for (int i = 0; i < 256; i++) poke(8'(i), 16'h0000);

      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_result", result, 16'h0);
      chk("rst_we", ram.ram_we, 1'b0);
      chk("rst_addr", ram.ram_addr, 8'h0);
      chk("rst_din", ram.ram_din, 16'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int j = 0; j < 7; j++) begin
         load_vec(tv[j]);
         run_op(tv[j].xb, tv[j].wb, tv[j].oa, tv[j].n, tv[j].b,
                tv[j].ex, 1'b0);
      end

      // start pulse while busy is ignored
      load_vec(tv[0]);
      run_op(tv[0].xb, tv[0].wb, tv[0].oa, tv[0].n, tv[0].b,
             tv[0].ex, 1'b1);

      // reset in the middle of an operation
      load_vec(tv[0]);
      w0 = we_cnt; d0 = done_cnt;
      x_base = tv[0].xb; w_base = tv[0].wb; out_addr = 8'h33;
      num_inputs = tv[0].n; bias = tv[0].b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_we", ram.ram_we, 1'b0);
      chk("mid_rst_addr", ram.ram_addr, 8'h0);
      chk("mid_rst_result", result, 16'h0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("mid_rst_writes", we_cnt - w0, 0);
      chk("mid_rst_dones", done_cnt - d0, 0);
      chk("mid_rst_mem", mem[8'h33], 16'h0);
      run_op(tv[0].xb, tv[0].wb, tv[0].oa, tv[0].n, tv[0].b,
             tv[0].ex, 1'b0);

      // randomized operations against the reference model
      for (int r = 0; r < 25; r++) begin
         n  = (r == 24) ? 256 : int'($urandom_range(0, 8));
         xb = 8'($urandom); wb = 8'($urandom); oa = 8'($urandom);
         b  = 16'($urandom);
         for (int i = 0; i < n; i++) begin
            poke(8'(xb + i), 16'($urandom));
            poke(8'(wb + i), 16'($urandom));
         end
         ex = model(xb, wb, n, b);
         run_op(xb, wb, oa, 9'(n), b, ex, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end
endmodule
